// File: rtl/nx_reg_indirect_access_mt_if.sv
// Command/status, hardware-write and array-view signals of the multi-table indirect register array.
interface nx_reg_indirect_access_mt_if #(
  parameter int N_TABLES    = 2,
  parameter int N_ENTRIES   = 8,
  parameter int N_DATA_BITS = 32
);
  localparam int TW = (N_TABLES  > 1) ? $clog2(N_TABLES)  : 1;
  localparam int AW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

  logic                   cmnd_stb;
  logic [3:0]             cmnd_op;
  logic [TW-1:0]          cmnd_table_id;
  logic [AW-1:0]          cmnd_addr;
  logic [N_DATA_BITS-1:0] wr_dat;
  logic [N_DATA_BITS-1:0] rst_dat [N_TABLES][N_ENTRIES];
  logic                   hw_we;
  logic [TW-1:0]          hw_table_id;
  logic [AW-1:0]          hw_addr;
  logic [N_DATA_BITS-1:0] hw_dat;
  logic                   busy;
  logic [2:0]             stat_code;
  logic [AW-1:0]          stat_addr;
  logic [TW-1:0]          stat_table_id;
  logic [4:0]             stat_datawords;
  logic [15:0]            capability_lst;
  logic [N_DATA_BITS-1:0] rd_dat;
  logic [N_DATA_BITS-1:0] mem_a [N_TABLES][N_ENTRIES];

  modport master (
    output cmnd_stb, cmnd_op, cmnd_table_id, cmnd_addr, wr_dat, rst_dat,
           hw_we, hw_table_id, hw_addr, hw_dat,
    input  busy, stat_code, stat_addr, stat_table_id, stat_datawords,
           capability_lst, rd_dat, mem_a
  );

  modport slave (
    input  cmnd_stb, cmnd_op, cmnd_table_id, cmnd_addr, wr_dat, rst_dat,
           hw_we, hw_table_id, hw_addr, hw_dat,
    output busy, stat_code, stat_addr, stat_table_id, stat_datawords,
           capability_lst, rd_dat, mem_a
  );
endinterface

// File: rtl/nx_reg_indirect_access_mt.sv
// Multi-table software-indirect register array with a sequencing FSM and a priority hardware write port.
// Optional per-entry even parity: define NX_REG_IA_PARITY_EN.
module nx_reg_indirect_access_mt #(
  parameter int N_TABLES    = 2,
  parameter int N_ENTRIES   = 8,
  parameter int N_DATA_BITS = 32
) (
  input logic                        clk,
  input logic                        rst_n,
  nx_reg_indirect_access_mt_if.slave bus
);
  localparam int TW = (N_TABLES  > 1) ? $clog2(N_TABLES)  : 1;
  localparam int AW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

  localparam logic [3:0] OP_NOP      = 4'd0;
  localparam logic [3:0] OP_READ     = 4'd1;
  localparam logic [3:0] OP_WRITE    = 4'd2;
  localparam logic [3:0] OP_RESET    = 4'd3;
  localparam logic [3:0] OP_INIT     = 4'd4;
  localparam logic [3:0] OP_INIT_INC = 4'd5;
  localparam logic [3:0] OP_COMPARE  = 4'd6;

  localparam logic [2:0] ST_OK         = 3'd0;
  localparam logic [2:0] ST_ADDR_ERR   = 3'd1;
  localparam logic [2:0] ST_OP_ERR     = 3'd2;
  localparam logic [2:0] ST_NO_MATCH   = 3'd3;
  localparam logic [2:0] ST_PARITY_ERR = 3'd4;

  localparam logic [4:0] DWORDS = 5'((N_DATA_BITS + 31) / 32);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SCAN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             op_q;
  logic [TW-1:0]          tbl_q;
  logic [AW-1:0]          addr_q;
  logic [AW-1:0]          idx_q, idx_d;
  logic [AW-1:0]          res_addr_q, res_addr_d;
  logic [2:0]             code_q, code_d;
  logic [N_DATA_BITS-1:0] rd_q, rd_d;
  logic [2:0]             stat_code_q;
  logic [AW-1:0]          stat_addr_q;
  logic [TW-1:0]          stat_tbl_q;

  logic [N_DATA_BITS-1:0] mem_w [N_TABLES][N_ENTRIES];
  logic                   tbl_ok, addr_ok, last_idx;
  logic [N_DATA_BITS-1:0] cmd_entry, scan_entry, fsm_wdat;
  logic [AW-1:0]          fsm_addr;
  logic                   fsm_we, tbl_rst, cmd_par_bad, scan_par_bad;

  assign tbl_ok     = 32'(tbl_q) < N_TABLES;
  assign addr_ok    = 32'(addr_q) < N_ENTRIES;
  assign last_idx   = 32'(idx_q) == N_ENTRIES - 1;
  assign cmd_entry  = (tbl_ok && addr_ok) ? mem_w[tbl_q][addr_q] : '0;
  assign scan_entry = tbl_ok ? mem_w[tbl_q][idx_q] : '0;

`ifdef NX_REG_IA_PARITY_EN
  logic par_w [N_TABLES][N_ENTRIES];
  assign cmd_par_bad  = tbl_ok && addr_ok && (par_w[tbl_q][addr_q] != ^cmd_entry);
  assign scan_par_bad = tbl_ok && (par_w[tbl_q][idx_q] != ^scan_entry);
`else
  assign cmd_par_bad  = 1'b0;
  assign scan_par_bad = 1'b0;
`endif

  // Per-entry storage; the hardware port wins, and the FSM never writes on a hw_we cycle anyway.
  generate
    for (genvar gi = 0; gi < N_TABLES; gi++) begin : g_tbl
      for (genvar gj = 0; gj < N_ENTRIES; gj++) begin : g_ent
        logic [N_DATA_BITS-1:0] ent_q;
        logic [N_DATA_BITS-1:0] ent_nxt;
        logic                   ent_we;

        always_comb begin
          ent_we  = 1'b0;
          ent_nxt = fsm_wdat;
          if (bus.hw_we && 32'(bus.hw_table_id) == gi && 32'(bus.hw_addr) == gj) begin
            ent_we  = 1'b1;
            ent_nxt = bus.hw_dat;
          end else if (tbl_rst && 32'(tbl_q) == gi) begin
            ent_we  = 1'b1;
            ent_nxt = bus.rst_dat[gi][gj];
          end else if (fsm_we && 32'(tbl_q) == gi && 32'(fsm_addr) == gj) begin
            ent_we  = 1'b1;
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)      ent_q <= bus.rst_dat[gi][gj];
          else if (ent_we) ent_q <= ent_nxt;
        end

`ifdef NX_REG_IA_PARITY_EN
        logic par_q;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)      par_q <= ^bus.rst_dat[gi][gj];
          else if (ent_we) par_q <= ^ent_nxt;
        end
        assign par_w[gi][gj] = par_q;
`endif
        assign mem_w[gi][gj]     = ent_q;
        assign bus.mem_a[gi][gj] = ent_q;
      end
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    code_d     = code_q;
    res_addr_d = res_addr_q;
    rd_d       = rd_q;
    fsm_we     = 1'b0;
    tbl_rst    = 1'b0;
    fsm_addr   = addr_q;
    fsm_wdat   = bus.wr_dat;
    case (state_q)
      S_IDLE: if (bus.cmnd_stb) state_d = S_EXEC;
      S_EXEC: if (!bus.hw_we) begin
        state_d    = S_DONE;
        code_d     = ST_OK;
        res_addr_d = addr_q;
        if (op_q > OP_COMPARE) begin
          code_d = ST_OP_ERR;
        end else if (op_q != OP_NOP && !tbl_ok) begin
          code_d = ST_ADDR_ERR;
        end else begin
          case (op_q)
            OP_READ: begin
              if (!addr_ok) code_d = ST_ADDR_ERR;
              else begin
                rd_d = cmd_entry;
                if (cmd_par_bad) code_d = ST_PARITY_ERR;
              end
            end
            OP_WRITE: begin
              if (!addr_ok) code_d = ST_ADDR_ERR;
              else begin
                fsm_we = 1'b1;
                rd_d   = bus.wr_dat;
              end
            end
            OP_RESET: tbl_rst = 1'b1;
            OP_INIT, OP_INIT_INC, OP_COMPARE: begin
              idx_d   = '0;
              state_d = S_SCAN;
            end
            default: ;
          endcase
        end
      end
      S_SCAN: if (!bus.hw_we) begin
        idx_d      = idx_q + 1'b1;
        res_addr_d = idx_q;
        fsm_addr   = idx_q;
        if (op_q == OP_COMPARE) begin
          if (scan_entry == bus.wr_dat) begin
            rd_d    = scan_entry;
            code_d  = scan_par_bad ? ST_PARITY_ERR : ST_OK;
            state_d = S_DONE;
          end else if (last_idx) begin
            rd_d    = '0;
            code_d  = ST_NO_MATCH;
            state_d = S_DONE;
          end
        end else begin
          fsm_we = 1'b1;
          if (op_q == OP_INIT_INC) fsm_wdat = bus.wr_dat + N_DATA_BITS'(idx_q);
          if (last_idx) begin
            code_d  = ST_OK;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status is published only on leaving DONE, so an aborted command never posts anything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      tbl_q       <= '0;
      addr_q      <= '0;
      idx_q       <= '0;
      res_addr_q  <= '0;
      code_q      <= '0;
      rd_q        <= '0;
      stat_code_q <= '0;
      stat_addr_q <= '0;
      stat_tbl_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      code_q     <= code_d;
      res_addr_q <= res_addr_d;
      rd_q       <= rd_d;
      if (state_q == S_IDLE && bus.cmnd_stb) begin
        op_q   <= bus.cmnd_op;
        tbl_q  <= bus.cmnd_table_id;
        addr_q <= bus.cmnd_addr;
      end
      if (state_q == S_DONE) begin
        stat_code_q <= code_q;
        stat_addr_q <= res_addr_q;
        stat_tbl_q  <= tbl_q;
      end
    end
  end

  assign bus.busy           = (state_q != S_IDLE);
  assign bus.stat_code      = stat_code_q;
  assign bus.stat_addr      = stat_addr_q;
  assign bus.stat_table_id  = stat_tbl_q;
  assign bus.stat_datawords = DWORDS;
  assign bus.capability_lst = 16'h007F;
  assign bus.rd_dat         = rd_q;
endmodule
